// File: rtl/ts_sync_monitor_pkg.sv
// ts_sync_monitor_pkg
// Shared constants and the FSM state encoding for the TS sync monitor.
// No ports.
package ts_sync_monitor_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } ts_state_e;

    function automatic logic is_sync_byte(input logic [7:0] b);
        return b == TS_SYNC_BYTE;
    endfunction

endpackage

// File: rtl/ts_sync_monitor_sat_counter.sv
// sat_counter
// W-bit statistics counter: counts up on inc_i, sticks at all-ones,
// clr_i zeroes it on the next edge and overrides a coincident inc_i.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous reset, active-low
//   inc_i  in   increment request
//   clr_i  in   synchronous clear
//   cnt_o  out  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ts_sync_monitor.sv
// ts_sync_monitor
// Locks onto the 0x47 sync byte of a byte-wide transport stream with a fixed
// PKT_LEN spacing, re-registers the stream and regenerates a clean packet
// start strobe. Lock status and statistics are exported for readout.
//
// Optional build macro: TS_SYNC_PSYNC_CHECK_EN
//   defined   -> P_SYNC_IN is compared against the locally derived packet
//                start on every valid byte in LOCK; mismatches are counted.
//   undefined -> no comparator, PSYNC_ERR_CNT is constant 0.
//
// Ports:
//   CLK            in   byte clock
//   RST            in   asynchronous reset, active-low
//   DATA_IN        in   TS byte
//   D_VALID_IN     in   byte qualifier
//   P_SYNC_IN      in   upstream packet-start flag (optional check only)
//   CLR_CNT        in   synchronous clear of all statistics counters
//   DATA_OUT       out  DATA_IN delayed one cycle
//   D_VALID_OUT    out  D_VALID_IN delayed one cycle
//   P_SYNC_OUT     out  regenerated packet start, only while locked
//   LOCKED         out  state machine is in LOCK
//   PKT_CNT        out  good packets seen in LOCK (saturating)
//   SYNC_ERR_CNT   out  missing sync bytes seen in LOCK (saturating)
//   PSYNC_ERR_CNT  out  P_SYNC_IN disagreements (saturating, optional)
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | searching for a 0x47 candidate on any valid byte
// VERIFY | candidate found; checking 0x47 recurs every PKT_LEN bytes
// LOCK   | aligned; counting packets and tolerating isolated misses
module ts_sync_monitor
    import ts_sync_monitor_pkg::*;
#(
    parameter int PKT_LEN    = TS_PKT_LEN,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       DATA_IN,
    input  logic             D_VALID_IN,
    input  logic             P_SYNC_IN,
    input  logic             CLR_CNT,
    output logic [7:0]       DATA_OUT,
    output logic             D_VALID_OUT,
    output logic             P_SYNC_OUT,
    output logic             LOCKED,
    output logic [CNT_W-1:0] PKT_CNT,
    output logic [CNT_W-1:0] SYNC_ERR_CNT,
    output logic [CNT_W-1:0] PSYNC_ERR_CNT
);

    localparam int POS_W  = $clog2(PKT_LEN);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(PKT_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_DONE = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_DONE  = BAD_W'(UNLOCK_CNT);

    ts_state_e         state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic [7:0]        data_q;
    logic              dvalid_q;
    logic              psync_q, psync_d;
    logic              pkt_inc;
    logic              err_inc;
    logic              is_sync;
    logic              check_pos;
    logic [POS_W-1:0]  pos_adv;

    assign is_sync   = is_sync_byte(DATA_IN);
    assign check_pos = (pos_q == '0);
    assign pos_adv   = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        good_d  = good_q;
        bad_d   = bad_q;
        pkt_inc = 1'b0;
        err_inc = 1'b0;
        psync_d = 1'b0;

        if (D_VALID_IN) begin
            case (state_q)
                HUNT: begin
                    // The candidate itself is position 0, so the next byte is 1.
                    if (is_sync) begin
                        state_d = VERIFY;
                        pos_d   = POS_W'(1);
                        good_d  = GOOD_W'(1);
                        bad_d   = '0;
                    end
                end
                VERIFY: begin
                    pos_d = pos_adv;
                    if (check_pos) begin
                        if (is_sync) begin
                            good_d = good_q + 1'b1;
                            if (good_d == GOOD_DONE) begin
                                state_d = LOCK;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCK: begin
                    pos_d = pos_adv;
                    if (check_pos) begin
                        if (is_sync) begin
                            bad_d   = '0;
                            pkt_inc = 1'b1;
                        end else begin
                            bad_d   = bad_q + 1'b1;
                            err_inc = 1'b1;
                            if (bad_d == BAD_DONE) begin
                                state_d = HUNT;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase

            // Alignment is trusted whenever we stay (or land) in LOCK, so a
            // missed sync byte still gets a start strobe.
            psync_d = check_pos && (state_q != HUNT) && (state_d == LOCK);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= HUNT;
            pos_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
            psync_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            data_q   <= DATA_IN;
            dvalid_q <= D_VALID_IN;
            psync_q  <= psync_d;
        end
    end

    assign DATA_OUT    = data_q;
    assign D_VALID_OUT = dvalid_q;
    assign P_SYNC_OUT  = psync_q;
    assign LOCKED      = (state_q == LOCK);

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .inc_i (pkt_inc),
        .clr_i (CLR_CNT),
        .cnt_o (PKT_CNT)
    );

    sat_counter #(.W(CNT_W)) u_sync_err_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .inc_i (err_inc),
        .clr_i (CLR_CNT),
        .cnt_o (SYNC_ERR_CNT)
    );

`ifdef TS_SYNC_PSYNC_CHECK_EN
    logic psync_mismatch;

    assign psync_mismatch = D_VALID_IN && (state_q == LOCK) && (P_SYNC_IN != check_pos);

    sat_counter #(.W(CNT_W)) u_psync_err_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .inc_i (psync_mismatch),
        .clr_i (CLR_CNT),
        .cnt_o (PSYNC_ERR_CNT)
    );
`else
    logic unused_p_sync_in;

    assign unused_p_sync_in = P_SYNC_IN;
    assign PSYNC_ERR_CNT    = '0;
`endif

endmodule

// File: tb/tb_ts_sync_monitor.sv
module tb_ts_sync_monitor;

    localparam int PLEN = 188;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DATA_IN = 8'h00;
    logic       D_VALID_IN = 1'b0;
    logic       P_SYNC_IN = 1'b0;
    logic       CLR_CNT = 1'b0;

    logic [7:0]  DATA_OUT;
    logic        D_VALID_OUT, P_SYNC_OUT, LOCKED;
    logic [15:0] PKT_CNT, SYNC_ERR_CNT, PSYNC_ERR_CNT;

    logic [7:0]  s_data;
    logic        s_valid, s_psync, s_locked;
    logic [2:0]  s_pkt, s_err, s_perr;

    ts_sync_monitor dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .D_VALID_IN(D_VALID_IN),
        .P_SYNC_IN(P_SYNC_IN), .CLR_CNT(CLR_CNT), .DATA_OUT(DATA_OUT),
        .D_VALID_OUT(D_VALID_OUT), .P_SYNC_OUT(P_SYNC_OUT), .LOCKED(LOCKED),
        .PKT_CNT(PKT_CNT), .SYNC_ERR_CNT(SYNC_ERR_CNT), .PSYNC_ERR_CNT(PSYNC_ERR_CNT)
    );

    // Narrow-counter instance on the same stream to reach saturation quickly.
    ts_sync_monitor #(.CNT_W(3)) u_small (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .D_VALID_IN(D_VALID_IN),
        .P_SYNC_IN(P_SYNC_IN), .CLR_CNT(CLR_CNT), .DATA_OUT(s_data),
        .D_VALID_OUT(s_valid), .P_SYNC_OUT(s_psync), .LOCKED(s_locked),
        .PKT_CNT(s_pkt), .SYNC_ERR_CNT(s_err), .PSYNC_ERR_CNT(s_perr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       v;
        logic       ps;
        logic       lk;
        int         pkt;
        int         err;
        int         perr;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int m_state, m_pos, m_good, m_bad, m_pkt, m_err, m_perr;
    int byte_idx;
    int first_lock_idx;

    function automatic int sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_good = 0; m_bad = 0;
        m_pkt = 0; m_err = 0; m_perr = 0;
        byte_idx = 0;
        first_lock_idx = -1;
    endtask

    task automatic model_step(input logic [7:0] d, input bit v, input bit ps,
                              input bit clr, output exp_t e);
        bit at0, pinc, einc, pe_inc;
        at0 = (m_pos == 0);
        pinc = 0; einc = 0; pe_inc = 0;
        e.ps = 1'b0;
        if (v) begin
            if (m_state == 2 && (ps != at0)) pe_inc = 1;
            if (m_state == 0) begin
                if (d == 8'h47) begin
                    m_state = 1; m_pos = 1; m_good = 1;
                end
            end else begin
                if (at0) begin
                    if (m_state == 1) begin
                        if (d == 8'h47) begin
                            m_good++;
                            if (m_good == 3) begin
                                m_state = 2; m_bad = 0; e.ps = 1'b1;
                            end
                        end else begin
                            m_state = 0;
                        end
                    end else begin
                        if (d == 8'h47) begin
                            m_bad = 0; pinc = 1; e.ps = 1'b1;
                        end else begin
                            m_bad++; einc = 1;
                            if (m_bad == 3) m_state = 0;
                            else e.ps = 1'b1;
                        end
                    end
                end
                m_pos = (m_pos + 1) % PLEN;
            end
        end
        if (clr) begin
            m_pkt = 0; m_err = 0; m_perr = 0;
        end else begin
            m_pkt += pinc; m_err += einc; m_perr += pe_inc;
        end
        e.data = d;
        e.v    = v;
        e.lk   = (m_state == 2);
        e.pkt  = m_pkt;
        e.err  = m_err;
        e.perr = m_perr;
    endtask

    task automatic send(input logic [7:0] d, input bit v, input bit ps, input bit clr);
        exp_t e, got;
        int perr_exp, perr_small;
        @(negedge CLK);
        DATA_IN = d; D_VALID_IN = v; P_SYNC_IN = ps; CLR_CNT = clr;
        model_step(d, v, ps, clr, e);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
`ifdef TS_SYNC_PSYNC_CHECK_EN
        perr_exp   = sat(got.perr, 16);
        perr_small = sat(got.perr, 3);
`else
        perr_exp   = 0;
        perr_small = 0;
`endif
        chk("data_out", 32'(DATA_OUT), 32'(got.data));
        chk("d_valid_out", 32'(D_VALID_OUT), 32'(got.v));
        chk("p_sync_out", 32'(P_SYNC_OUT), 32'(got.ps));
        chk("locked", 32'(LOCKED), 32'(got.lk));
        chk("pkt_cnt", 32'(PKT_CNT), sat(got.pkt, 16));
        chk("sync_err_cnt", 32'(SYNC_ERR_CNT), sat(got.err, 16));
        chk("psync_err_cnt", 32'(PSYNC_ERR_CNT), perr_exp);
        chk("small_pkt_cnt", 32'(s_pkt), sat(got.pkt, 3));
        chk("small_err_cnt", 32'(s_err), sat(got.err, 3));
        chk("small_perr_cnt", 32'(s_perr), perr_small);
        if (v) begin
            if (LOCKED && first_lock_idx < 0) first_lock_idx = byte_idx;
            byte_idx++;
        end
    endtask

    task automatic send_pkt(input logic [7:0] first, input int gap_pct = 0,
                            input int ps_off = 0, input int clr_idx = -1,
                            input int nbytes = PLEN);
        for (int i = 0; i < nbytes; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
                send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
            send((i == 0) ? first : 8'h00, 1'b1, (i == ps_off), (i == clr_idx));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, 32'(DATA_OUT), 0);
        chk({tag, "_valid"}, 32'(D_VALID_OUT), 0);
        chk({tag, "_psync"}, 32'(P_SYNC_OUT), 0);
        chk({tag, "_locked"}, 32'(LOCKED), 0);
        chk({tag, "_pkt"}, 32'(PKT_CNT), 0);
        chk({tag, "_err"}, 32'(SYNC_ERR_CNT), 0);
        chk({tag, "_perr"}, 32'(PSYNC_ERR_CNT), 0);
        chk({tag, "_small_pkt"}, 32'(s_pkt), 0);
    endtask

    initial begin
        model_reset();

        // Power-on reset.
        #1 RST = 1'b0;
        #1 check_all_zero("reset");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // 1: clean stream, lock on the third sync byte.
        repeat (3) send_pkt(8'h47);
        chk("t1_first_lock_idx", first_lock_idx, 2 * PLEN);
        chk("t1_locked", 32'(LOCKED), 1);
        chk("t1_pkt_at_lock", 32'(PKT_CNT), 0);
        repeat (2) send_pkt(8'h47);
        chk("t1_pkt_after2", 32'(PKT_CNT), 2);

        // 2: single corrupted sync keeps lock; three in a row drop it.
        send_pkt(8'h46);
        chk("t2_err1", 32'(SYNC_ERR_CNT), 1);
        chk("t2_still_locked", 32'(LOCKED), 1);
        send_pkt(8'h47, 0, 0, 5);
        chk("t2_clr_pkt", 32'(PKT_CNT), 0);
        chk("t2_clr_err", 32'(SYNC_ERR_CNT), 0);
        repeat (3) send_pkt(8'h46);
        chk("t2_unlocked", 32'(LOCKED), 0);
        chk("t2_err3", 32'(SYNC_ERR_CNT), 3);

        // 3: false sync, then true alignment 101 bytes later.
        send_pkt(8'h47, 0, 0, -1, 101);
        repeat (3) send_pkt(8'h47);
        chk("t3_not_locked", 32'(LOCKED), 0);
        send_pkt(8'h47);
        chk("t3_locked", 32'(LOCKED), 1);
        chk("t3_pkt", 32'(PKT_CNT), 0);

        // 4: 30% valid gaps in the locked stream.
        repeat (4) send_pkt(8'h47, 30);
        chk("t4_err_unchanged", 32'(SYNC_ERR_CNT), 3);
        chk("t4_pkt", 32'(PKT_CNT), 4);
        chk("t4_locked", 32'(LOCKED), 1);

        // 5: clear coincident with increment, then saturation.
        send_pkt(8'h47, 0, 0, 0);
        chk("t5_clr_wins", 32'(PKT_CNT), 0);
        repeat (8) send_pkt(8'h47);
        chk("t5_pkt8", 32'(PKT_CNT), 8);
        chk("t5_small_sat", 32'(s_pkt), 7);

        // P_SYNC_IN shifted by one byte.
        send_pkt(8'h47, 0, 0, 0);
        repeat (2) send_pkt(8'h47, 0, 1);
`ifdef TS_SYNC_PSYNC_CHECK_EN
        chk("psync_offset", 32'(PSYNC_ERR_CNT), 4);
`else
        chk("psync_offset", 32'(PSYNC_ERR_CNT), 0);
`endif

        // 6: reset mid-packet while locked, then full relock.
        send_pkt(8'h47, 0, 0, -1, 50);
        @(posedge CLK);
        #2;
        D_VALID_IN = 1'b0; CLR_CNT = 1'b0; P_SYNC_IN = 1'b0;
        RST = 1'b0;
        #1 check_all_zero("t6_async");
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) send_pkt(8'h47);
        chk("t6_not_locked", 32'(LOCKED), 0);
        send_pkt(8'h47);
        chk("t6_relock_idx", first_lock_idx, 2 * PLEN);
        chk("t6_locked", 32'(LOCKED), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
